// File: rtl/l1_port_arbiter_pkg.sv
// Shared L1 types: requester IDs, the captured-request record and the read tag
// that is queued while a read is outstanding.
package l1_port_arbiter_pkg;

    localparam int unsigned L1_CONNECTIONS = 4;
    localparam int unsigned L1_ADDR_W      = 32;
    localparam int unsigned L1_DATA_W      = 32;
    localparam int unsigned L1_SIZE_W      = 5;

    typedef enum logic [1:0] {
        DCACHE = 2'd0,
        DMMU   = 2'd1,
        ICACHE = 2'd2,
        IMMU   = 2'd3
    } l1_id_t;

    typedef struct packed {
        logic [L1_ADDR_W-1:0]   addr;
        logic                   rnw;
        logic [L1_DATA_W/8-1:0] be;
        logic [L1_DATA_W-1:0]   wdata;
        logic [L1_SIZE_W-1:0]   size;
        l1_id_t                 id;
    } l1_arb_request_t;

    typedef struct packed {
        l1_id_t               id;
        logic [L1_SIZE_W-1:0] size;
    } l1_rd_tag_t;

endpackage

// File: rtl/l1_port_arbiter_fifo.sv
// Generic synchronous FIFO used as the outstanding-read ID queue.
// DEPTH must be a power of two so the pointers wrap naturally.
module l1_port_arbiter_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        din_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Ring buffer storage, pointers and occupancy; reset empties it at once
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l1_port_arbiter.sv
// Round-robin arbiter sharing the L1 memory request channel among the
// caches/MMUs, with a registered output stage and read-response routing
// driven by a queue of outstanding read tags.
module l1_port_arbiter
    import l1_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = L1_CONNECTIONS,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = L1_ADDR_W,
    parameter int unsigned DATA_W          = L1_DATA_W,
    parameter int unsigned SIZE_W          = L1_SIZE_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]        req_rnw,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*SIZE_W-1:0] req_size,
    output logic                        mem_request,
    input  logic                        mem_ack,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rnw,
    output logic [DATA_W/8-1:0]         mem_be,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [SIZE_W-1:0]           mem_size,
    output logic [1:0]                  mem_id,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data
);

    localparam int unsigned        PORT_W  = $clog2(NUM_PORTS);
    localparam int unsigned        CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic              mem_request_q, mem_request_d;
    l1_arb_request_t   out_q, out_d;
    logic [PORT_W-1:0] rr_last_q, rr_last_d;
    logic [SIZE_W-1:0] beat_q, beat_d;

    logic              free;
    logic              read_ok;
    logic              grant;
    logic [PORT_W-1:0] sel;
    logic [PORT_W-1:0] cand;
    logic [CNT_W-1:0]  reserved;

    logic              q_push;
    logic              q_pop;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    l1_rd_tag_t        q_tag;
    l1_rd_tag_t        q_head;

    assign free     = !mem_request_q || mem_ack;
    // An unacked read sitting in the output register already owns a queue slot.
    assign reserved = q_count + CNT_W'(mem_request_q && out_q.rnw);
    assign read_ok  = (reserved < MAX_CNT);

    // Round-robin search starting just after the last granted port
    always_comb begin
        grant = 1'b0;
        sel   = rr_last_q;
        cand  = rr_last_q;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = PORT_W'((32'(rr_last_q) + i) % NUM_PORTS);
            if (!grant && req_valid[cand] && (!req_rnw[cand] || read_ok)) begin
                grant = 1'b1;
                sel   = cand;
            end
        end
    end

    assign req_ready = (!rst && free && grant) ? (NUM_PORTS'(1) << sel) : '0;

    // Output register: load the winner when free, otherwise hold until acked
    always_comb begin
        mem_request_d = mem_request_q;
        out_d         = out_q;
        rr_last_d     = rr_last_q;
        if (free) begin
            mem_request_d = grant;
            if (grant) begin
                out_d.addr  = req_addr[32'(sel)*ADDR_W +: ADDR_W];
                out_d.rnw   = req_rnw[sel];
                out_d.be    = req_be[32'(sel)*(DATA_W/8) +: DATA_W/8];
                out_d.wdata = req_wdata[32'(sel)*DATA_W +: DATA_W];
                out_d.size  = req_size[32'(sel)*SIZE_W +: SIZE_W];
                out_d.id    = l1_id_t'(sel);
                rr_last_d   = sel;
            end
        end
    end

    // Route each read beat to the port at the queue head and count its beats
    always_comb begin
        rsp_valid = '0;
        q_pop     = 1'b0;
        beat_d    = beat_q;
        if (!rst && mem_rvalid && !q_empty) begin
            rsp_valid[q_head.id] = 1'b1;
            if (beat_q == q_head.size) begin
                q_pop  = 1'b1;
                beat_d = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    assign rsp_data = mem_rdata;

    // State registers for the output stage, round-robin pointer and beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_request_q <= 1'b0;
            out_q         <= '0;
            rr_last_q     <= PORT_W'(NUM_PORTS - 1);
            beat_q        <= '0;
        end else begin
            mem_request_q <= mem_request_d;
            out_q         <= out_d;
            rr_last_q     <= rr_last_d;
            beat_q        <= beat_d;
        end
    end

    assign q_push = mem_request_q && mem_ack && out_q.rnw;
    assign q_tag  = '{id: out_q.id, size: out_q.size};

    l1_port_arbiter_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (2 + SIZE_W)
    ) u_id_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .din_i   (q_tag),
        .pop_i   (q_pop),
        .dout_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    assign mem_request = mem_request_q;
    assign mem_addr    = out_q.addr;
    assign mem_rnw     = out_q.rnw;
    assign mem_be      = out_q.be;
    assign mem_wdata   = out_q.wdata;
    assign mem_size    = out_q.size;
    assign mem_id      = out_q.id;

    // A read beat with nothing outstanding has no destination and is discarded
    always_ff @(posedge clk) begin
        if (!rst && mem_rvalid) begin
            assert (!q_empty)
                else $warning("l1_port_arbiter: read beat with empty ID queue dropped");
        end
    end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Bench for l1_port_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_l1_port_arbiter;

    localparam int NP   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 5;
    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP-1:0]     req_rnw = '0;
    logic [NP*DW/8-1:0] req_be = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic [NP*SW-1:0]  req_size = '0;
    logic              mem_request;
    logic              mem_ack = 1'b0;
    logic [AW-1:0]     mem_addr;
    logic              mem_rnw;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_size;
    logic [1:0]        mem_id;
    logic              mem_rvalid = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;

    l1_port_arbiter #(
        .NUM_PORTS       (NP),
        .MAX_OUTSTANDING (MAXO),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .SIZE_W          (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rnw     (req_rnw),
        .req_be      (req_be),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .mem_request (mem_request),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_rnw     (mem_rnw),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_size    (mem_size),
        .mem_id      (mem_id),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Reference model state
    bit              m_pend;
    int              m_last;
    logic [AW-1:0]   m_addr;
    logic            m_rnw;
    logic [DW/8-1:0] m_be;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_size;
    int              m_id;
    int              rdq_port[$];
    int              rdq_left[$];

    // Observation logs for the literal checks
    int              gnt_log[$];
    int              rsp_port_log[$];
    logic [DW-1:0]   rsp_data_log[$];
    logic [NP-1:0]   seen_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One cycle of the reference model, evaluated at the falling edge
    task automatic model_cycle();
        logic [NP-1:0] exp_ready;
        logic [NP-1:0] exp_rsp;
        int  reserved;
        int  pick;
        bit  free;
        exp_ready = '0;
        exp_rsp   = '0;
        pick      = -1;
        free      = !m_pend || mem_ack;
        reserved  = rdq_port.size() + ((m_pend && m_rnw) ? 1 : 0);
        if (!rst) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (pick < 0 && req_valid[p] && (!req_rnw[p] || reserved < MAXO)) pick = p;
            end
        end
        if (free && pick >= 0) exp_ready[pick] = 1'b1;

        if (!rst && mem_rvalid && rdq_port.size() > 0) begin
            exp_rsp[rdq_port[0]] = 1'b1;
            rdq_left[0]--;
            if (rdq_left[0] == 0) begin
                void'(rdq_port.pop_front());
                void'(rdq_left.pop_front());
            end
        end

        if (started) begin
            check("req_ready", req_ready, exp_ready);
            check("mem_request", mem_request, m_pend);
            if (m_pend) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_rnw", mem_rnw, m_rnw);
                check("mem_id", mem_id, m_id);
                check("mem_size", mem_size, m_size);
                check("mem_be", mem_be, m_be);
                check("mem_wdata", mem_wdata, m_wdata);
            end
            check("rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != '0) check("rsp_data", rsp_data, mem_rdata);
        end

        seen_ready = req_ready;
        if (req_ready != '0) gnt_log.push_back(oh2idx(req_ready));
        if (rsp_valid != '0) begin
            rsp_port_log.push_back(oh2idx(rsp_valid));
            rsp_data_log.push_back(rsp_data);
        end

        if (!rst && m_pend && mem_ack && m_rnw) begin
            rdq_port.push_back(m_id);
            rdq_left.push_back(int'(m_size) + 1);
        end

        if (rst) begin
            m_pend = 1'b0;
            m_last = NP - 1;
            rdq_port.delete();
            rdq_left.delete();
        end else if (free) begin
            if (pick >= 0) begin
                m_pend  = 1'b1;
                m_last  = pick;
                m_addr  = req_addr[pick*AW +: AW];
                m_rnw   = req_rnw[pick];
                m_be    = req_be[pick*(DW/8) +: DW/8];
                m_wdata = req_wdata[pick*DW +: DW];
                m_size  = req_size[pick*SW +: SW];
                m_id    = pick;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    // Check at the falling edge, then let requesters drop granted requests
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~seen_ready;
    endtask

    task automatic set_req(input int p, input logic rnw, input logic [AW-1:0] addr,
                           input logic [SW-1:0] size, input logic [DW/8-1:0] be,
                           input logic [DW-1:0] wdata);
        req_addr[p*AW +: AW]       = addr;
        req_rnw[p]                 = rnw;
        req_size[p*SW +: SW]       = size;
        req_be[p*(DW/8) +: DW/8]   = be;
        req_wdata[p*DW +: DW]      = wdata;
        req_valid[p]               = 1'b1;
    endtask

    task automatic wait_grant(input int p);
        for (int n = 0; n < 20 && req_valid[p]; n++) tick();
        check("grant_timeout", req_valid[p], 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        mem_rvalid = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        started = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int bg;
        int br;
        bit re;

        // Port 2 burst read of 4 words, routed back in order
        do_reset();
        mem_ack = 1'b1;
        br = rsp_port_log.size();
        set_req(2, 1'b1, 32'h8000_0040, 5'd3, '0, '0);
        tick();
        check("t1_mem_id", mem_id, 2'd2);
        check("t1_mem_addr", mem_addr, 32'h8000_0040);
        tick();
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + i);
        tick();
        check("t1_beats", rsp_port_log.size() - br, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_port", rsp_port_log[br+i], 2);
            check("t1_data", rsp_data_log[br+i], 32'hA0 + i);
        end

        // All ports at once, port 0 re-requests after its grant
        do_reset();
        mem_ack = 1'b1;
        bg = gnt_log.size();
        re = 1'b0;
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 32'h1000 + p, '0, 4'hF, 32'h11 * p);
        for (int n = 0; n < 8; n++) begin
            tick();
            if (!re && !req_valid[0]) begin
                set_req(0, 1'b0, 32'h1100, '0, 4'hF, 32'h55);
                re = 1'b1;
            end
        end
        check("t2_grants", gnt_log.size() - bg, 5);
        check("t2_g0", gnt_log[bg+0], 0);
        check("t2_g1", gnt_log[bg+1], 1);
        check("t2_g2", gnt_log[bg+2], 2);
        check("t2_g3", gnt_log[bg+3], 3);
        check("t2_g4", gnt_log[bg+4], 0);

        // Downstream stall: request held, no new capture until ack
        do_reset();
        mem_ack = 1'b0;
        bg = gnt_log.size();
        set_req(1, 1'b0, 32'h2000_0010, '0, 4'h3, 32'hDEAD_BEEF);
        tick();
        set_req(2, 1'b0, 32'h2000_0020, '0, 4'hC, 32'h0BAD_F00D);
        for (int n = 0; n < 5; n++) tick();
        check("t3_hold_addr", mem_addr, 32'h2000_0010);
        check("t3_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_hold_grants", gnt_log.size() - bg, 1);
        mem_ack = 1'b1;
        tick();
        check("t3_ack_grants", gnt_log.size() - bg, 2);
        check("t3_ack_port", gnt_log[bg+1], 2);
        check("t3_next_addr", mem_addr, 32'h2000_0020);
        tick();

        // Outstanding-read limit blocks reads but not writes
        do_reset();
        mem_ack = 1'b1;
        for (int r = 0; r < MAXO; r++) begin
            set_req(1, 1'b1, 32'h3000_0000 + r, '0, '0, '0);
            wait_grant(1);
        end
        tick();
        bg = gnt_log.size();
        set_req(1, 1'b0, 32'h3100_0000, '0, 4'hF, 32'h77);
        set_req(2, 1'b1, 32'h3200_0000, '0, '0, '0);
        for (int n = 0; n < 4; n++) tick();
        check("t4_write_only", gnt_log.size() - bg, 1);
        check("t4_write_port", gnt_log[bg], 1);
        br = rsp_port_log.size();
        send_beat(32'hB0);
        check("t4_beat_port", rsp_port_log[br], 1);
        check("t4_beat_data", rsp_data_log[br], 32'hB0);
        check("t4_still_blocked", gnt_log.size() - bg, 1);
        tick();
        check("t4_unblocked", gnt_log.size() - bg, 2);
        check("t4_read_port", gnt_log[bg+1], 2);

        // Write is never queued; a stray beat afterwards goes nowhere
        do_reset();
        mem_ack = 1'b1;
        set_req(3, 1'b0, 32'h6000_0000, '0, 4'hF, 32'h1234_5678);
        wait_grant(3);
        check("t5_mem_id", mem_id, 2'd3);
        check("t5_mem_rnw", mem_rnw, 1'b0);
        tick();
        tick();
        br = rsp_port_log.size();
        send_beat(32'hEE);
        tick();
        check("t5_no_rsp", rsp_port_log.size() - br, 0);

        // Reset in the middle of a burst, then a clean read
        do_reset();
        mem_ack = 1'b1;
        set_req(0, 1'b1, 32'h0000_4000, 5'd3, '0, '0);
        wait_grant(0);
        tick();
        send_beat(32'hC0);
        send_beat(32'hC1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_req", mem_request, 1'b0);
        check("t6_rst_rsp", rsp_valid, '0);
        check("t6_rst_ready", req_ready, '0);
        br = rsp_port_log.size();
        send_beat(32'hC2);
        send_beat(32'hC3);
        check("t6_dropped", rsp_port_log.size() - br, 0);
        set_req(0, 1'b1, 32'h0000_5000, 5'd1, '0, '0);
        wait_grant(0);
        tick();
        br = rsp_port_log.size();
        send_beat(32'hD0);
        send_beat(32'hD1);
        tick();
        check("t6_beats", rsp_port_log.size() - br, 2);
        check("t6_p0", rsp_port_log[br], 0);
        check("t6_d0", rsp_data_log[br], 32'hD0);
        check("t6_p1", rsp_port_log[br+1], 0);
        check("t6_d1", rsp_data_log[br+1], 32'hD1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l1_port_arbiter.md
Name: l1_port_arbiter

Overview:
- Shares the single L1 memory request channel among the L1_CONNECTIONS requesters, indexed by l1_id_t: DCACHE=0, DMMU=1, ICACHE=2, IMMU=3.
- Round-robin grant with one registered output stage.
- Tracks outstanding reads in an ID queue and routes returning read beats to the originating port.
- Sits between the caches/MMUs and the external bus adapter.

Parameters:
- NUM_PORTS, 4, number of requesters; equals L1_CONNECTIONS.
- MAX_OUTSTANDING, 4, maximum reads acknowledged but not fully returned; power of 2, ≥2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- SIZE_W, 5, burst length field; value = words-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_PORTS  per-port request pending.
- req_ready  out  NUM_PORTS  one-hot; request captured this cycle.
- req_addr  in  NUM_PORTS*ADDR_W  word address.
- req_rnw  in  NUM_PORTS  1=read, 0=write.
- req_be  in  NUM_PORTS*DATA_W/8  byte enables (writes).
- req_wdata  in  NUM_PORTS*DATA_W  write data.
- req_size  in  NUM_PORTS*SIZE_W  burst words-1 (reads); writes are single-word.
- mem_request  out  1  downstream request valid.
- mem_ack  in  1  downstream accepted request.
- mem_addr, mem_rnw, mem_be, mem_wdata, mem_size  out  as above  captured request fields.
- mem_id  out  2  l1_id_t of the captured request.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  DATA_W  read beat data.
- rsp_valid  out  NUM_PORTS  one-hot read beat to a port.
- rsp_data  out  DATA_W  read beat data, shared by all ports.

Behaviour:
- Clock and reset are fixed: one clock clk; rst is synchronous and active-high.
- Reset state: mem_request=0; rsp_valid=0; req_ready=0; ID queue empty; beat counter=0; rr_last=NUM_PORTS-1, so port 0 has first priority.
- Output register: "free" when mem_request=0 or mem_ack=1 in the same cycle.
- Arbitration, when free: select the first valid eligible port searching rr_last+1 .. rr_last+NUM_PORTS, wrapping modulo NUM_PORTS.
- Capture: assert req_ready[sel] for one cycle (combinational from this cycle's state). Next cycle: mem_request=1 with the selected fields; rr_last=sel.
- Holding: mem_request and all mem_* fields are held stable until mem_ack. Back-to-back capture is allowed in the mem_ack cycle, giving one request per cycle throughput.
- Eligibility: a read port is ineligible when reserved reads ≥ MAX_OUTSTANDING.
  - reserved = queue count + (1 if the output register holds an unacked read).
  - Writes are always eligible.
- Requesters must hold req_valid and fields until req_ready. Dropping req_valid earlier is illegal.
- ID queue push: on mem_ack with mem_rnw=1, push {mem_id, mem_size}.
- Response routing, on mem_rvalid:
  - rsp_valid[head.id]=1 and rsp_data=mem_rdata, combinationally, zero latency.
  - Beat counter increments; when it equals head.size, pop the head and clear the counter.
- Simultaneous push and pop in one cycle: count unchanged; no loss.
- mem_rvalid with the queue empty: rsp_valid stays 0, the beat is dropped, and a simulation assertion fires.
- Writes: never enqueued and produce no rsp_valid.
- Reset mid-burst: queue, counter and output register clear immediately. Beats arriving after reset are dropped per the empty rule.

Decomposition:
- Shared package: l1_id_t and L1_CONNECTIONS (existing), plus a new l1_arb_request_t packed struct {addr, rnw, be, wdata, size, id} for ports and the output register.
- Sub-module: the ID queue as a generic fifo instance, depth MAX_OUTSTANDING, width 2+SIZE_W.
- Round-robin select stays inline.

Test Plan:
- Port 2 reads addr 0x80000040, size 3, with immediate ack. Then 4 mem_rvalid beats 0xA0..0xA3: rsp_valid[2] pulses 4 times with data in order, queue empties, and mem_id=2 during the request.
- All four ports valid simultaneously and mem_ack always 1: grant order 0,1,2,3. Port 0 re-requests; next grant is port 0 only after port 3.
- mem_ack held low for 5 cycles: mem_request and fields stay constant, no further req_ready, and the capture completes in the ack cycle.
- MAX_OUTSTANDING=4 reads acked with no beats returned: a fifth read is not granted while a pending write from port 1 is granted. One beat completing a size-0 read unblocks the fifth read the next cycle.
- Port 3 writes 0x60000000, be=0xF: acked, no queue entry, no rsp_valid. A subsequent stray mem_rvalid fires the assertion and produces no response.
- rst asserted after 2 of 4 beats: all outputs at reset values next cycle, and the next read from port 0 routes correctly.
